// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory responder for the MEM stage; stalls the
//            pipeline for 1+LATENCY cycles per load/store access.
// Options  : DMEM_ERR_EN adds err_o and misaligned/out-of-range checking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] data_o,
  output logic        stall_o
`ifdef DMEM_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [C_AW-1:0] r_addr;
  logic [31:0]    r_wdata;
  logic           r_we;
  logic           r_bad;
  logic [31:0]    r_data;
  logic [31:0]    r_mem [DEPTH];

  logic w_req;
  logic w_accept;
  logic w_access;
  logic w_bad;
  logic w_unused_addr;

  assign w_req = MemRead_i | MemWrite_i;

  // Bits outside the word index are only meaningful to the error checker.
  assign w_unused_addr = ^{Address_i[31:C_AW+2], Address_i[1:0]};

`ifdef DMEM_ERR_EN
  assign w_bad = (|Address_i[1:0]) | ((Address_i >> (C_AW + 2)) != 32'd0);
`else
  assign w_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated by reset so a request held during reset never freezes the pipe.
  assign stall_o = rst_i & (((r_state == IDLE) & w_req) | (r_state == BUSY));
  assign data_o  = r_data;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= Address_i[C_AW+1:2];
        r_wdata <= WriteData_i;
        r_we    <= MemWrite_i;
        r_bad   <= w_bad;
        r_cnt   <= 4'(LATENCY - 1);
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !r_we) begin
        r_data <= r_bad ? 32'd0 : r_mem[r_addr];
      end
    end
  end

  // Array has no reset; an async reset mid-BUSY leaves IDLE so the store never fires.
  always_ff @(posedge clk_i) begin
    if (w_access && r_we && !r_bad) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

`ifdef DMEM_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_access & r_bad;
    end
  end

  assign err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rd0, wr0, stall0, err0;
  logic [31:0] addr0, wd0, data0;
  logic        rst1, rd1, wr1, stall1, err1;
  logic [31:0] addr1, wd1, data1;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst0), .MemRead_i(rd0), .MemWrite_i(wr0),
    .Address_i(addr0), .WriteData_i(wd0), .data_o(data0), .stall_o(stall0)
`ifdef DMEM_ERR_EN
    , .err_o(err0)
`endif
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .Address_i(addr1), .WriteData_i(wd1), .data_o(data1), .stall_o(stall1)
`ifdef DMEM_ERR_EN
    , .err_o(err1)
`endif
  );

`ifndef DMEM_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
    end
  endtask

  // Runs one access; returns stall-cycle count and the DONE-cycle outputs.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int nstall, output logic [31:0] data, output logic err);
    logic done;
    logic s;
    done   = 1'b0;
    nstall = 0;
    @(negedge clk);
    drive(sel, rd, wr, addr, wd);
    for (int i = 0; i < 40; i++) begin
      #1;
      s = (sel == 0) ? stall0 : stall1;
      if (s) begin
        nstall++;
        @(negedge clk);
      end else begin
        done = 1'b1;
        break;
      end
    end
    data = (sel == 0) ? data0 : data1;
    err  = (sel == 0) ? err0 : err1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    check("access_completes", {31'd0, done}, 32'd1);
  endtask

  int          ns;
  logic [31:0] d;
  logic        e;
  logic [7:0]  pattern;

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("reset_stall_low", {31'd0, stall0}, 32'd0);
    check("reset_data_zero", data0, 32'd0);
    check("reset_err_zero", {31'd0, err0}, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst0 = 1'b1; rst1 = 1'b1;

    // Preload word 0 through a store, then load it back.
    access(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, ns, d, e);
    check("preload_stall", ns, 32'd3);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, ns, d, e);
    check("load0_stall", ns, 32'd3);
    check("load0_data", d, 32'hA5A5_0001);

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, ns, d, e);
    check("store10_stall", ns, 32'd3);
    check("store_keeps_data", d, 32'hA5A5_0001);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, d, e);
    check("load10_data", d, 32'hDEAD_BEEF);

`ifndef DMEM_ERR_EN
    // Index 0x104 wraps to word 4; low bits are ignored.
    access(0, 1'b1, 1'b0, 32'h412, 32'h0, ns, d, e);
    check("wrap_load_data", d, 32'hDEAD_BEEF);
`endif

    // Back-to-back loads held on the inputs.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      pattern[7-i] = stall0;
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("b2b_stall_pattern", {24'd0, pattern}, 32'h0000_00EE);

    // Reset in the middle of a store's BUSY window.
    access(0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, ns, d, e);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, ns, d, e);
    check("preres_data", d, 32'hA5A5_0001);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h3333_4444);
    #1;
    check("mid_store_stall", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    rst0 = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("midbusy_rst_stall", {31'd0, stall0}, 32'd0);
    check("midbusy_rst_data", data0, 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, ns, d, e);
    check("post_rst_stall", ns, 32'd3);
    check("post_rst_old_val", d, 32'h1111_2222);

`ifdef DMEM_ERR_EN
    access(0, 1'b0, 1'b1, 32'h13, 32'h0BAD_0BAD, ns, d, e);
    check("err_store_stall", ns, 32'd3);
    check("err_store_err", {31'd0, e}, 32'd1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, d, e);
    check("err_store_mem", d, 32'hDEAD_BEEF);
    check("ok_load_err", {31'd0, e}, 32'd0);
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, ns, d, e);
    check("err_load_data", d, 32'd0);
    check("err_load_err", {31'd0, e}, 32'd1);
`endif

    // LATENCY=1 instance: read+write together behaves as a store.
    access(1, 1'b1, 1'b1, 32'h8, 32'h5, ns, d, e);
    check("lat1_rw_stall", ns, 32'd2);
    check("lat1_rw_data", d, 32'd0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, ns, d, e);
    check("lat1_load_stall", ns, 32'd2);
    check("lat1_load_data", d, 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
